// File: rtl/async_fifo_core.sv
// async_fifo_core: single-clock Gray-pointer FIFO keeping the dual-clock synchronizer structure.
// Optional occupancy outputs p_write_level/p_read_level are enabled by defining ASYNC_FIFO_LEVEL_EN.
module async_fifo_core #(
    parameter int BITS        = 32,
    parameter int SIZE        = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      p_write_en,
    input  logic [BITS-1:0]           p_write_data,
    output logic                      p_write_full,
    input  logic                      p_read_en,
    output logic [BITS-1:0]           p_read_data,
    output logic                      p_read_empty
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    output logic [$clog2(SIZE):0]     p_write_level,
    output logic [$clog2(SIZE):0]     p_read_level
`endif
);
    localparam int ADDR = $clog2(SIZE);
    // Full when the write pointer equals the read pointer with its top two Gray bits inverted.
    localparam logic [ADDR:0] FULL_MASK = (ADDR+1)'(3) << (ADDR-1);
    logic [BITS-1:0] r_mem [SIZE];
    logic [BITS-1:0] r_rdata;
    logic [ADDR:0]   r_wbin, r_wgray, r_rbin, r_rgray;
    logic [ADDR:0]   r_wq [SYNC_STAGES];
    logic [ADDR:0]   r_rq [SYNC_STAGES];
    logic            r_full, r_empty;
    logic            w_wr_acc, w_rd_acc;
    logic [ADDR:0]   w_wbin_next, w_wgray_next, w_rbin_next, w_rgray_next;
    assign w_wr_acc     = p_write_en && !r_full;
    assign w_rd_acc     = p_read_en && !r_empty;
    assign w_wbin_next  = r_wbin + (ADDR+1)'(w_wr_acc);
    assign w_rbin_next  = r_rbin + (ADDR+1)'(w_rd_acc);
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
    assign p_write_full = r_full;
    assign p_read_empty = r_empty;
    assign p_read_data  = r_rdata;
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wbin[ADDR-1:0]] <= p_write_data;
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= w_wgray_next == (r_rq[SYNC_STAGES-1] ^ FULL_MASK);
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rbin  <= '0;
            r_rgray <= '0;
            r_empty <= 1'b1;
            r_rdata <= '0;
        end else begin
            r_rbin  <= w_rbin_next;
            r_rgray <= w_rgray_next;
            r_empty <= w_rgray_next == r_wq[SYNC_STAGES-1];
            if (w_rd_acc) r_rdata <= r_mem[r_rbin[ADDR-1:0]];
        end
    end
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wq <= '{default: '0};
            r_rq <= '{default: '0};
        end else begin
            r_wq[0] <= r_wgray;
            r_rq[0] <= r_rgray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wq[i] <= r_wq[i-1];
                r_rq[i] <= r_rq[i-1];
            end
        end
    end
`ifdef ASYNC_FIFO_LEVEL_EN
    function automatic logic [ADDR:0] g2b(input logic [ADDR:0] g);
        logic [ADDR:0] b;
        b[ADDR] = g[ADDR];
        for (int i = ADDR - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_write_level <= '0;
            p_read_level  <= '0;
        end else begin
            p_write_level <= w_wbin_next - g2b(r_rq[SYNC_STAGES-1]);
            p_read_level  <= g2b(r_wq[SYNC_STAGES-1]) - w_rbin_next;
        end
    end
`endif
endmodule

// File: tb/tb_async_fifo_core.sv
// tb_async_fifo_core: directed vector table plus scoreboard-driven sequences for async_fifo_core.
module tb_async_fifo_core;
    typedef struct {
        logic        rstn;
        logic        we;
        logic [31:0] wd;
        logic        re;
        logic        e_empty;
        logic        e_full;
        logic [31:0] e_data;
    } vec_t;
    logic        clk = 1'b0, rstn = 1'b0, we = 1'b0, re = 1'b0;
    logic [31:0] wd = '0;
    logic [31:0] rd;
    logic        empty, full;
    logic [31:0] q[$];
    logic [31:0] last_rd = '0;
    int          tests = 0, fails = 0;
    vec_t        tv[16];

    async_fifo_core #(.BITS(32), .SIZE(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rstn(rstn),
        .p_write_en(we), .p_write_data(wd), .p_write_full(full),
        .p_read_en(re), .p_read_data(rd), .p_read_empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One clock with flag-gated acceptance mirrored in the scoreboard.
    task automatic cycle(input logic w, input logic [31:0] d, input logic r);
        logic wa, ra;
        wa = w && !full;
        ra = r && !empty;
        we = w; wd = d; re = r;
        tick();
        if (wa) q.push_back(d);
        if (ra) begin
            if (q.size() == 0) chk("rd_underflow", 32'(q.size()), 32'd1);
            else chk("rd_data", rd, q.pop_front());
        end else if (r) chk("rd_hold", rd, last_rd);
        last_rd = rd;
        if (!full) chk("no_overflow", 32'(q.size() < 16), 32'd1);
        if (!empty) chk("no_underflow", 32'(q.size() > 0), 32'd1);
        we = 1'b0; re = 1'b0;
    endtask

    task automatic do_reset;
        rstn = 1'b0; we = 1'b1; re = 1'b1; wd = 32'hAA;
        repeat (3) tick();
        rstn = 1'b1; we = 1'b0; re = 1'b0;
        q.delete();
        last_rd = '0;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_data", rd, 32'd0);
    endtask

    task automatic drain(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            logic can;
            can = !empty;
            cycle(1'b0, '0, 1'b1);
            if (can) got++;
        end
        chk("drain_cnt", 32'(got), 32'(n));
    endtask

    initial begin
        int tog;
        logic pf;
        tv[0]  = '{1'b0, 1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b1, 32'hAA, 1'b1, 1'b1, 1'b0, 32'h0};
        tv[3]  = '{1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 32'h0};
        tv[4]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};
        tv[5]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};
        tv[6]  = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h0};
        tv[7]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h11};
        tv[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h11};
        tv[9]  = '{1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 32'h11};
        tv[10] = '{1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 32'h11};
        tv[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h11};
        tv[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 32'h11};
        tv[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h22};
        tv[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h33};
        tv[15] = '{1'b1, 1'b1, 32'h44, 1'b1, 1'b1, 1'b0, 32'h33};
        #2;
        for (int i = 0; i < 16; i++) begin
            rstn = tv[i].rstn; we = tv[i].we; wd = tv[i].wd; re = tv[i].re;
            tick();
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tv[i].e_empty));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(tv[i].e_full));
            chk($sformatf("vec%0d_data", i), rd, tv[i].e_data);
        end

        do_reset();
        for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), 1'b0);
        repeat (4) cycle(1'b0, '0, 1'b0);
        drain(16, 40);
        for (int w = 0; w < 4 && empty !== 1'b1; w++) cycle(1'b0, '0, 1'b0);
        chk("smoke_empty", 32'(empty), 32'd1);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'h100 + 32'(i), 1'b0);
            if (i == 14) chk("fill_notfull15", 32'(full), 32'd0);
        end
        chk("fill_full16", 32'(full), 32'd1);
        cycle(1'b1, 32'h110, 1'b0);
        chk("fill_full17", 32'(full), 32'd1);
        cycle(1'b0, '0, 1'b1);
        chk("full_lat0", 32'(full), 32'd1);
        cycle(1'b0, '0, 1'b0);
        chk("full_lat1", 32'(full), 32'd1);
        cycle(1'b0, '0, 1'b0);
        chk("full_lat2", 32'(full), 32'd1);
        cycle(1'b0, '0, 1'b0);
        chk("full_lat3", 32'(full), 32'd0);
        drain(15, 30);
        chk("fill_empty", 32'(empty), 32'd1);

        repeat (3) cycle(1'b1, 32'h55, 1'b0);
        rstn = 1'b0; we = 1'b1; re = 1'b1; wd = 32'h66;
        tick();
        rstn = 1'b1; we = 1'b0; re = 1'b0;
        q.delete();
        last_rd = '0;
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_full", 32'(full), 32'd0);
        chk("midrst_data", rd, 32'd0);
        cycle(1'b1, 32'h77, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b0);
        drain(1, 10);
        chk("midrst_after", 32'(empty), 32'd1);

        void'($urandom(7));
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));

        do_reset();
        tog = 0;
        for (int i = 0; i < 150; i++) begin
            pf = full;
            cycle(1'b1, 32'h2000 + 32'(i), i % 3 == 0);
            if (full !== pf) tog++;
        end
        chk("prod_full_toggles", 32'(tog >= 2), 32'd1);

        tog = 0;
        for (int i = 0; i < 150; i++) begin
            pf = empty;
            cycle(i % 3 == 0, 32'h3000 + 32'(i), 1'b1);
            if (empty !== pf) tog++;
        end
        chk("cons_empty_toggles", 32'(tog >= 2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
